hazard_forward_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage RISC-V core.
- Tracks destination registers of instructions in EX, MEM and WB in shadow registers.
- Drives the registered 2-bit forward selects consumed by the EX-stage ALU operand mux.
- Detects load-use hazards and sequences IF/ID stall plus EX bubble insertion; honours branch flush and global freeze.

---
 rtl/riscv_pkg.sv | 28 ++
 rtl/hazard_fwd_sel.sv | 24 ++
 rtl/hazard_forward_ctrl.sv | 173 +++++++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared pipeline definitions for the RISC-V core: forward-select encodings,
// shadow stage entry and the register-match helper used by the hazard logic.
package riscv_pkg;

  localparam int XLEN_REGS_DEF = 32;
  localparam int REG_IDX_W     = $clog2(XLEN_REGS_DEF);

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic                 regwrite;
    logic                 memread;
  } stage_t;

  localparam stage_t STAGE_EMPTY = '{default: '0};

  typedef enum logic {ST_RUN, ST_LU_STALL} hz_state_e;

  // x0 is hardwired zero, so it never produces a value worth forwarding.
  function automatic logic writes_reg(stage_t e, logic [REG_IDX_W-1:0] r);
    return e.valid && e.regwrite && (e.rd != '0) && (e.rd == r);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forward select: the younger producer (EX, about to become MEM)
// wins over the older one (MEM, about to become WB).
module hazard_fwd_sel
  import riscv_pkg::*;
(
  input  logic                 uses_i,
  input  logic [REG_IDX_W-1:0] rs_i,
  input  stage_t               ex_i,
  input  stage_t               mem_i,
  output logic [1:0]           sel_o
);

  logic unused_memread;
  assign unused_memread = ex_i.memread ^ mem_i.memread;

  always_comb begin
    sel_o = FWD_REG;
    if (uses_i) begin
      if (writes_reg(ex_i, rs_i))       sel_o = FWD_MEM;
      else if (writes_reg(mem_i, rs_i)) sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller for the 5-stage core: shadow EX/MEM/WB entries,
// registered forward selects, load-use stall FSM. HAZARD_STATS_EN adds counters.
module hazard_forward_ctrl
  import riscv_pkg::*;
#(
  parameter int LOAD_USE_CYCLES = 1,
  parameter int XLEN_REGS       = 32,
  localparam int RIDX_W         = $clog2(XLEN_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic [RIDX_W-1:0] id_rs1_i,
  input  logic [RIDX_W-1:0] id_rs2_i,
  input  logic              id_uses_rs1_i,
  input  logic              id_uses_rs2_i,
  input  logic [RIDX_W-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              flush_i,
  input  logic              freeze_i,
  output logic [1:0]        forward1_o,
  output logic [1:0]        forward2_o,
  output logic              stall_id_o,
  output logic              bubble_ex_o
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stat_stall_cnt_o,
  output logic [31:0]       stat_fwd_cnt_o
`endif
);

  localparam int CNT_W = 2;

  stage_t           ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, id_e;
  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       fwd1_q, fwd1_d, fwd2_q, fwd2_d;
  logic [1:0]       sel1, sel2;
  logic             load_use, lu_cycle, stall, bubble;

  // WB is tracked for pipeline fidelity; nothing forwards from a retiring entry.
  logic unused_wb;
  assign unused_wb = ^wb_q;

  always_comb begin
    id_e          = STAGE_EMPTY;
    id_e.valid    = id_valid_i;
    id_e.rd       = id_rd_i;
    id_e.regwrite = id_valid_i && id_regwrite_i && (id_rd_i != '0);
    id_e.memread  = id_valid_i && id_memread_i;
  end

  hazard_fwd_sel u_sel1 (
    .uses_i (id_valid_i && id_uses_rs1_i),
    .rs_i   (id_rs1_i),
    .ex_i   (ex_q),
    .mem_i  (mem_q),
    .sel_o  (sel1)
  );

  hazard_fwd_sel u_sel2 (
    .uses_i (id_valid_i && id_uses_rs2_i),
    .rs_i   (id_rs2_i),
    .ex_i   (ex_q),
    .mem_i  (mem_q),
    .sel_o  (sel2)
  );

  assign load_use = id_valid_i && ex_q.memread &&
                    ((id_uses_rs1_i && writes_reg(ex_q, id_rs1_i)) ||
                     (id_uses_rs2_i && writes_reg(ex_q, id_rs2_i)));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    cnt_d    = cnt_q;
    ex_d     = ex_q;
    mem_d    = mem_q;
    wb_d     = wb_q;
    fwd1_d   = fwd1_q;
    fwd2_d   = fwd2_q;
    stall    = 1'b0;
    bubble   = 1'b0;
    lu_cycle = 1'b0;
    if (freeze_i) begin
      stall = 1'b1;
    end else begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (flush_i) begin
        bubble  = 1'b1;
        state_d = ST_RUN;
        cnt_d   = '0;
      end else if (state_q == ST_LU_STALL) begin
        stall    = 1'b1;
        bubble   = 1'b1;
        lu_cycle = 1'b1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_d == '0) state_d = ST_RUN;
      end else if (load_use) begin
        stall    = 1'b1;
        bubble   = 1'b1;
        lu_cycle = 1'b1;
        cnt_d    = CNT_W'(LOAD_USE_CYCLES - 1);
        state_d  = (cnt_d != '0) ? ST_LU_STALL : ST_RUN;
      end
      if (bubble) begin
        ex_d   = STAGE_EMPTY;
        fwd1_d = FWD_REG;
        fwd2_d = FWD_REG;
      end else begin
        ex_d   = id_e;
        fwd1_d = sel1;
        fwd2_d = sel2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      ex_q    <= STAGE_EMPTY;
      mem_q   <= STAGE_EMPTY;
      wb_q    <= STAGE_EMPTY;
      state_q <= ST_RUN;
      cnt_q   <= '0;
      fwd1_q  <= FWD_REG;
      fwd2_q  <= FWD_REG;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fwd1_q  <= fwd1_d;
      fwd2_q  <= fwd2_d;
    end
  end

  assign forward1_o  = fwd1_q;
  assign forward2_o  = fwd2_q;
  assign stall_id_o  = stall;
  assign bubble_ex_o = bubble;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, lu_cycle};
    fwd_cnt_d   = fwd_cnt_q;
    if (!freeze_i && !bubble && ((fwd1_d != FWD_REG) || (fwd2_d != FWD_REG)))
      fwd_cnt_d = fwd_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stat_stall_cnt_o = stall_cnt_q;
  assign stat_fwd_cnt_o   = fwd_cnt_q;
`else
  logic unused_lu;
  assign unused_lu = lu_cycle;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl; two instances cover LOAD_USE_CYCLES=1 and 3.
module tb_hazard_forward_ctrl;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } instr_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid_i, id_uses_rs1_i, id_uses_rs2_i, id_regwrite_i, id_memread_i;
  logic [4:0] id_rs1_i, id_rs2_i, id_rd_i;
  logic       flush_i, freeze_i;
  logic [1:0] f1_a, f2_a, f1_b, f2_b;
  logic       st_a, bu_a, st_b, bu_b;

  int vectors     = 0;
  int miscompares = 0;

`ifdef HAZARD_STATS_EN
  logic [31:0] ss_a, sf_a, ss_b, sf_b;
`endif

  always #5 clk = ~clk;

  hazard_forward_ctrl #(.LOAD_USE_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i),
    .id_rs2_i(id_rs2_i), .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
    .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
    .flush_i(flush_i), .freeze_i(freeze_i), .forward1_o(f1_a), .forward2_o(f2_a),
    .stall_id_o(st_a), .bubble_ex_o(bu_a)
`ifdef HAZARD_STATS_EN
    , .stat_stall_cnt_o(ss_a), .stat_fwd_cnt_o(sf_a)
`endif
  );

  hazard_forward_ctrl #(.LOAD_USE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i),
    .id_rs2_i(id_rs2_i), .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
    .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
    .flush_i(flush_i), .freeze_i(freeze_i), .forward1_o(f1_b), .forward2_o(f2_b),
    .stall_id_o(st_b), .bubble_ex_o(bu_b)
`ifdef HAZARD_STATS_EN
    , .stat_stall_cnt_o(ss_b), .stat_fwd_cnt_o(sf_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic instr_t nop();
    return '0;
  endfunction

  function automatic instr_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    instr_t i = '0;
    i.v = 1'b1; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.u1 = 1'b1; i.u2 = 1'b1; i.rw = 1'b1;
    return i;
  endfunction

  function automatic instr_t lw(input logic [4:0] rd, input logic [4:0] rs1);
    instr_t i = alu(rd, rs1, 5'd0);
    i.u2 = 1'b0; i.mr = 1'b1;
    return i;
  endfunction

  // Apply one ID instruction just after the rising edge; return at the falling edge for checks.
  task automatic cyc(input instr_t i, input logic fl, input logic fz);
    @(posedge clk); #1;
    id_valid_i = i.v;   id_rs1_i = i.rs1; id_rs2_i = i.rs2;
    id_uses_rs1_i = i.u1; id_uses_rs2_i = i.u2;
    id_rd_i = i.rd;     id_regwrite_i = i.rw; id_memread_i = i.mr;
    flush_i = fl;       freeze_i = fz;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    {id_valid_i, id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i} = '0;
    {id_rd_i, id_regwrite_i, id_memread_i, flush_i, freeze_i} = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int stall_seen;
    logic [3:0] exp_stall3;
    instr_t use8;

    do_reset();
    @(negedge clk);
    check("rst_fwd1", {30'd0, f1_a}, 32'd0);
    check("rst_fwd2", {30'd0, f2_a}, 32'd0);
    check("rst_stall", {31'd0, st_a}, 32'd0);
    check("rst_bubble", {31'd0, bu_a}, 32'd0);

    // add x5 ; add x6,x5,x1 -> EX sees forward1=01
    cyc(alu(5'd5, 5'd1, 5'd2), 1'b0, 1'b0);
    cyc(alu(5'd6, 5'd5, 5'd1), 1'b0, 1'b0);
    check("b2b_stall", {31'd0, st_a}, 32'd0);
    cyc(nop(), 1'b0, 1'b0);
    check("b2b_fwd1", {30'd0, f1_a}, 32'd1);
    check("b2b_fwd2", {30'd0, f2_a}, 32'd0);

    // add x5 ; nop ; sub x7,x2,x5 -> forward2=10
    do_reset();
    cyc(alu(5'd5, 5'd1, 5'd2), 1'b0, 1'b0);
    cyc(nop(), 1'b0, 1'b0);
    cyc(alu(5'd7, 5'd2, 5'd5), 1'b0, 1'b0);
    cyc(nop(), 1'b0, 1'b0);
    check("gap_fwd1", {30'd0, f1_a}, 32'd0);
    check("gap_fwd2", {30'd0, f2_a}, 32'd2);

    // add x5 ; add x5 ; use x5 -> younger producer wins (01)
    do_reset();
    cyc(alu(5'd5, 5'd1, 5'd2), 1'b0, 1'b0);
    cyc(alu(5'd5, 5'd3, 5'd4), 1'b0, 1'b0);
    cyc(alu(5'd10, 5'd5, 5'd3), 1'b0, 1'b0);
    cyc(nop(), 1'b0, 1'b0);
    check("prio_fwd1", {30'd0, f1_a}, 32'd1);
    check("prio_fwd2", {30'd0, f2_a}, 32'd0);

    // lw x8 ; add x9,x8,x8 with LOAD_USE_CYCLES=1
    use8 = alu(5'd9, 5'd8, 5'd8);
    do_reset();
    cyc(lw(5'd8, 5'd1), 1'b0, 1'b0);
    check("lu1_pre_stall", {31'd0, st_a}, 32'd0);
    cyc(use8, 1'b0, 1'b0);
    check("lu1_stall", {31'd0, st_a}, 32'd1);
    check("lu1_bubble", {31'd0, bu_a}, 32'd1);
    cyc(use8, 1'b0, 1'b0);
    check("lu1_release_stall", {31'd0, st_a}, 32'd0);
    check("lu1_release_bubble", {31'd0, bu_a}, 32'd0);
    check("lu1_bubble_fwd1", {30'd0, f1_a}, 32'd0);
    cyc(nop(), 1'b0, 1'b0);
    check("lu1_fwd1", {30'd0, f1_a}, 32'd2);
    check("lu1_fwd2", {30'd0, f2_a}, 32'd2);
    check("lu1_post_stall", {31'd0, st_a}, 32'd0);

    // Same sequence with LOAD_USE_CYCLES=3: three stall cycles then regfile
    do_reset();
    exp_stall3 = 4'b0111;
    stall_seen = 0;
    cyc(lw(5'd8, 5'd1), 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc(use8, 1'b0, 1'b0);
      check($sformatf("lu3_stall_c%0d", k), {31'd0, st_b}, {31'd0, exp_stall3[k]});
      check($sformatf("lu3_bubble_c%0d", k), {31'd0, bu_b}, {31'd0, exp_stall3[k]});
      if (st_b) stall_seen++;
    end
    check("lu3_stall_total", stall_seen, 32'd3);
    cyc(nop(), 1'b0, 1'b0);
    check("lu3_fwd1", {30'd0, f1_b}, 32'd0);
    check("lu3_fwd2", {30'd0, f2_b}, 32'd0);

    // x0 is never a forward or hazard source
    do_reset();
    cyc(alu(5'd0, 5'd1, 5'd2), 1'b0, 1'b0);
    cyc(alu(5'd3, 5'd0, 5'd0), 1'b0, 1'b0);
    cyc(lw(5'd0, 5'd1), 1'b0, 1'b0);
    check("x0_fwd1", {30'd0, f1_a}, 32'd0);
    check("x0_fwd2", {30'd0, f2_a}, 32'd0);
    cyc(alu(5'd4, 5'd0, 5'd0), 1'b0, 1'b0);
    check("x0_lu_stall", {31'd0, st_a}, 32'd0);
    cyc(nop(), 1'b0, 1'b0);
    check("x0_lu_fwd1", {30'd0, f1_a}, 32'd0);

    // Load-use hazard coincident with flush
    do_reset();
    cyc(lw(5'd8, 5'd1), 1'b0, 1'b0);
    cyc(use8, 1'b1, 1'b0);
    check("flush_stall_a", {31'd0, st_a}, 32'd0);
    check("flush_bubble_a", {31'd0, bu_a}, 32'd1);
    check("flush_stall_b", {31'd0, st_b}, 32'd0);
    cyc(use8, 1'b0, 1'b0);
    check("flush_run_b", {31'd0, st_b}, 32'd0);
    check("flush_ex_fwd", {30'd0, f1_b}, 32'd0);
    cyc(nop(), 1'b0, 1'b0);
    check("flush_after_fwd1", {30'd0, f1_b}, 32'd2);

    // Freeze held for 4 cycles inside LU_STALL (LOAD_USE_CYCLES=3)
    do_reset();
    cyc(lw(5'd8, 5'd1), 1'b0, 1'b0);
    cyc(use8, 1'b0, 1'b0);
    cyc(use8, 1'b0, 1'b0);
    check("frz_pre_stall", {31'd0, st_b}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      cyc(use8, 1'b0, 1'b1);
      check($sformatf("frz_stall_c%0d", k), {31'd0, st_b}, 32'd1);
      check($sformatf("frz_bubble_c%0d", k), {31'd0, bu_b}, 32'd0);
      check($sformatf("frz_fwd1_c%0d", k), {30'd0, f1_b}, 32'd0);
    end
    cyc(use8, 1'b0, 1'b0);
    check("frz_resume_stall", {31'd0, st_b}, 32'd1);
    check("frz_resume_bubble", {31'd0, bu_b}, 32'd1);
    cyc(use8, 1'b0, 1'b0);
    check("frz_done_stall", {31'd0, st_b}, 32'd0);
    cyc(nop(), 1'b0, 1'b0);
    check("frz_done_fwd1", {30'd0, f1_b}, 32'd0);

    // Asynchronous reset in the middle of LU_STALL
    do_reset();
    cyc(lw(5'd8, 5'd1), 1'b0, 1'b0);
    cyc(use8, 1'b0, 1'b0);
    cyc(use8, 1'b0, 1'b0);
    check("arst_pre_stall", {31'd0, st_b}, 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_stall", {31'd0, st_b}, 32'd0);
    check("arst_bubble", {31'd0, bu_b}, 32'd0);
    check("arst_fwd", {28'd0, f1_b, f2_b}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
